// File: rtl/keypad_emulator_if.sv
// Key-code push channel into the keypad emulator: a producer offers a
// 4-bit key code with a valid strobe and the emulator answers with ready.
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    // Producer side: offers codes, watches ready
    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    // Emulator side: accepts codes, reports ready
    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );
endinterface

// File: rtl/keypad_emulator.sv
// Keypad emulator: replays queued key codes onto the active-low row lines of
// a 4x4 keypad, answering the decoder's column scan. Each key is held for
// HOLD_CYCLES, then released for GAP_CYCLES, so the decoder sees exactly one
// press and one release per key.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 16_000_000,
    parameter int GAP_CYCLES  = 16_000_000,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 31
) (
    input  logic                          clk,
    input  logic                          rst_n,
    keypad_emulator_if.slave              key_if,
    input  logic [3:0]                    col,
    output logic [3:0]                    row,
    output logic                          busy,
    output logic                          key_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [3:0]       lat_col_q, lat_col_d;
    logic [3:0]       lat_row_q, lat_row_d;
    logic [3:0]       row_q, row_d;
    logic             key_done_q, key_done_d;
    logic [3:0]       mem_q [FIFO_DEPTH];

    logic             push;
    logic             pop;

    // Key code -> {column pattern, row pattern}, both active-low one-cold
    function automatic logic [7:0] key_map(input logic [3:0] code);
        case (code)
            4'h1:    key_map = 8'b0111_0111;
            4'h4:    key_map = 8'b0111_1011;
            4'h7:    key_map = 8'b0111_1101;
            4'h0:    key_map = 8'b0111_1110;
            4'h2:    key_map = 8'b1011_0111;
            4'h5:    key_map = 8'b1011_1011;
            4'h8:    key_map = 8'b1011_1101;
            4'hF:    key_map = 8'b1011_1110;
            4'h3:    key_map = 8'b1101_0111;
            4'h6:    key_map = 8'b1101_1011;
            4'h9:    key_map = 8'b1101_1101;
            4'hE:    key_map = 8'b1101_1110;
            4'hA:    key_map = 8'b1110_0111;
            4'hB:    key_map = 8'b1110_1011;
            4'hC:    key_map = 8'b1110_1101;
            default: key_map = 8'b1110_1110; // 4'hD
        endcase
    endfunction

    // A full queue refuses pushes outright, even if a pop frees a slot this cycle
    assign key_if.key_ready = (count_q != COUNT_FULL);
    assign push             = key_if.key_valid && key_if.key_ready;

    // Sequencer: pop a code when idle, then time the hold and the release gap
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_col_d  = lat_col_q;
        lat_row_d  = lat_row_q;
        key_done_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop                    = 1'b1;
                    {lat_col_d, lat_row_d} = key_map(mem_q[rd_ptr_q]);
                    cnt_d                  = '0;
                    state_d                = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d      = '0;
                    key_done_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Queue bookkeeping and the row answer to the current column strobe
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + COUNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - COUNT_ONE;
        end
        // Only the exact latched column pattern is answered; anything else reads as released
        row_d = ((state_q == PRESS) && (col == lat_col_q)) ? lat_row_q : 4'b1111;
    end

    // State, counter, queue pointers and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lat_col_q  <= 4'b1111;
            lat_row_q  <= 4'b1111;
            row_q      <= 4'b1111;
            key_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lat_col_q  <= lat_col_d;
            lat_row_q  <= lat_row_d;
            row_q      <= row_d;
            key_done_q <= key_done_d;
        end
    end

    // Queue storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= key_if.key_code;
        end
    end

    assign row        = row_q;
    assign key_done   = key_done_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: reset, single key timing, the full
// key map, FIFO-full behaviour, reset during a press, and a loopback through a
// simple scanning decoder model.
module tb_keypad_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    keypad_emulator_if kif ();
    keypad_emulator_if lif ();

    logic [3:0] col, row;
    logic       busy, key_done;
    logic [2:0] fifo_count;

    logic [3:0] lb_col, lb_row;
    logic       lb_busy, lb_done;
    logic [2:0] lb_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] cap_q [$];

    keypad_emulator #(
        .HOLD_CYCLES (20),
        .GAP_CYCLES  (10),
        .FIFO_DEPTH  (4),
        .CNT_W       (31)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_if     (kif),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .key_done   (key_done),
        .fifo_count (fifo_count)
    );

    keypad_emulator #(
        .HOLD_CYCLES (200),
        .GAP_CYCLES  (200),
        .FIFO_DEPTH  (4),
        .CNT_W       (31)
    ) u_lb (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_if     (lif),
        .col        (lb_col),
        .row        (lb_row),
        .busy       (lb_busy),
        .key_done   (lb_done),
        .fifo_count (lb_count)
    );

    // Hand-written key table: {column pattern, row pattern}
    function automatic logic [7:0] exp_map(input logic [3:0] c);
        case (c)
            4'h0: exp_map = 8'b0111_1110;
            4'h1: exp_map = 8'b0111_0111;
            4'h2: exp_map = 8'b1011_0111;
            4'h3: exp_map = 8'b1101_0111;
            4'h4: exp_map = 8'b0111_1011;
            4'h5: exp_map = 8'b1011_1011;
            4'h6: exp_map = 8'b1101_1011;
            4'h7: exp_map = 8'b0111_1101;
            4'h8: exp_map = 8'b1011_1101;
            4'h9: exp_map = 8'b1101_1101;
            4'hA: exp_map = 8'b1110_0111;
            4'hB: exp_map = 8'b1110_1011;
            4'hC: exp_map = 8'b1110_1101;
            4'hD: exp_map = 8'b1110_1110;
            4'hE: exp_map = 8'b1101_1110;
            default: exp_map = 8'b1011_1110;
        endcase
    endfunction

    function automatic logic [3:0] code_of(input logic [3:0] c, input logic [3:0] r);
        logic [3:0] k;
        code_of = 4'h0;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            if (exp_map(k) == {c, r}) code_of = k;
        end
    endfunction

    // Scanning decoder model: one column every SCAN_INTERVAL cycles, row sampled
    // at the end of each slot, press state updated after each full scan
    localparam int SCAN_INTERVAL = 10;
    int         scan_cnt;
    logic [1:0] col_idx;
    logic       hit;
    logic [3:0] hit_code;
    logic [3:0] dec_out;
    logic       button_pressed;

    assign lb_col = ~(4'b1000 >> col_idx);

    always @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt       <= 0;
            col_idx        <= 2'd0;
            hit            <= 1'b0;
            hit_code       <= 4'h0;
            dec_out        <= 4'h0;
            button_pressed <= 1'b0;
        end else if (scan_cnt == SCAN_INTERVAL - 1) begin
            scan_cnt <= 0;
            col_idx  <= col_idx + 2'd1;
            if (col_idx == 2'd3) begin
                if (lb_row != 4'hF) begin
                    button_pressed <= 1'b1;
                    dec_out        <= code_of(lb_col, lb_row);
                end else if (hit) begin
                    button_pressed <= 1'b1;
                    dec_out        <= hit_code;
                end else begin
                    button_pressed <= 1'b0;
                end
                hit <= 1'b0;
            end else if (lb_row != 4'hF) begin
                hit      <= 1'b1;
                hit_code <= code_of(lb_col, lb_row);
            end
        end else begin
            scan_cnt <= scan_cnt + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        kif.key_valid = 1'b1;
        kif.key_code  = 4'h5;
        col           = 4'b1011;
        repeat (3) tick;
        checks++; if (row !== 4'b1111) begin errors++; $display("FAIL reset_row: got %b expected 1111", row); end
        checks++; if (kif.key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", kif.key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (key_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", key_done); end
        kif.key_valid = 1'b0;
        col           = 4'b1111;
        rst_n         = 1'b1;
        tick;
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_no_push: got %0d expected 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", busy); end
        $display("reset: done");
    endtask

    task automatic test_single;
        kif.key_code  = 4'h5;
        kif.key_valid = 1'b1;
        tick;
        kif.key_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        tick;
        col = 4'b1011;
        tick;
        checks++; if (row !== 4'b1011) begin errors++; $display("FAIL single_hit: got %b expected 1011", row); end
        col = 4'b0111;
        tick;
        checks++; if (row !== 4'b1111) begin errors++; $display("FAIL single_wrong_col: got %b expected 1111", row); end
        col = 4'b1011;
        tick;
        checks++; if (row !== 4'b1011) begin errors++; $display("FAIL single_rehit: got %b expected 1011", row); end
        repeat (17) tick;
        checks++; if (row !== 4'b1011) begin errors++; $display("FAIL single_last_press: got %b expected 1011", row); end
        tick;
        checks++; if (row !== 4'b1111) begin errors++; $display("FAIL single_released: got %b expected 1111", row); end
        for (int p = 0; p < 4; p++) begin
            col = ~(4'b1000 >> p);
            tick;
            checks++; if (row !== 4'b1111) begin errors++; $display("FAIL single_gap_row: col %b got %b expected 1111", col, row); end
        end
        col = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (key_done !== 1'b0) begin errors++; $display("FAIL single_early_done: got %b expected 0", key_done); end
        end
        tick;
        checks++; if (key_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b expected 1", key_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
        tick;
        checks++; if (key_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", key_done); end
        $display("single: key 5 played");
    endtask

    task automatic test_full_map;
        logic [3:0] pats [6];
        logic [7:0] m;
        logic [3:0] exp_row;
        logic       done_seen;
        pats = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
        for (int c = 0; c < 16; c++) begin
            m             = exp_map(4'(c));
            kif.key_code  = 4'(c);
            kif.key_valid = 1'b1;
            tick;
            kif.key_valid = 1'b0;
            tick;
            for (int k = 0; k < 6; k++) begin
                col     = pats[k];
                exp_row = (pats[k] == m[7:4]) ? m[3:0] : 4'b1111;
                tick;
                checks++;
                if (row !== exp_row) begin
                    errors++;
                    $display("FAIL map_row: code %h col %b got %b expected %b", c, pats[k], row, exp_row);
                end
            end
            col       = 4'b1111;
            done_seen = 1'b0;
            for (int i = 0; i < 60 && !done_seen; i++) begin
                tick;
                if (key_done) done_seen = 1'b1;
            end
            checks++; if (!done_seen) begin errors++; $display("FAIL map_done: code %h got no key_done expected pulse", c); end
            $display("map: code %h checked", c);
        end
    endtask

    task automatic capture_keys(input int n, input int budget, output int ndone);
        logic got;
        int   idx;
        got   = 1'b0;
        idx   = 0;
        ndone = 0;
        cap_q.delete();
        for (int i = 0; i < budget && ndone < n; i++) begin
            col = ~(4'b1000 >> idx);
            idx = (idx + 1) % 4;
            tick;
            if (row != 4'b1111 && !got) begin
                cap_q.push_back(code_of(col, row));
                got = 1'b1;
                $display("capture: key %h pressed", code_of(col, row));
            end
            if (key_done) begin
                ndone++;
                got = 1'b0;
            end
        end
        col = 4'b1111;
    endtask

    task automatic test_fifo_full;
        logic [3:0] seq [5];
        int         ndone;
        seq = '{4'h3, 4'h6, 4'h9, 4'hE, 4'hA};
        for (int i = 0; i < 5; i++) begin
            kif.key_code  = seq[i];
            kif.key_valid = 1'b1;
            tick;
            if (i == 1) begin
                checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL full_push_pop: got %0d expected 1", fifo_count); end
            end
        end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
        checks++; if (kif.key_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", kif.key_ready); end
        kif.key_code = 4'hB;
        tick;
        kif.key_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_drop: got %0d expected 4", fifo_count); end
        capture_keys(5, 400, ndone);
        checks++; if (ndone != 5) begin errors++; $display("FAIL full_done_cnt: got %0d expected 5", ndone); end
        checks++; if (cap_q.size() != 5) begin errors++; $display("FAIL full_played_cnt: got %0d expected 5", cap_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < cap_q.size()) begin
                checks++; if (cap_q[i] !== seq[i]) begin errors++; $display("FAIL full_order: slot %0d got %h expected %h", i, cap_q[i], seq[i]); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_idle: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        logic row_bad;
        logic done_bad;
        int   idx;
        kif.key_code  = 4'h1;
        kif.key_valid = 1'b1;
        tick;
        kif.key_code  = 4'h2;
        tick;
        kif.key_valid = 1'b0;
        col = 4'b0111;
        tick;
        checks++; if (row !== 4'b0111) begin errors++; $display("FAIL midrst_pressed: got %b expected 0111", row); end
        rst_n = 1'b0;
        tick;
        checks++; if (row !== 4'b1111) begin errors++; $display("FAIL midrst_row: got %b expected 1111", row); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
        checks++; if (key_done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", key_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        rst_n    = 1'b1;
        row_bad  = 1'b0;
        done_bad = 1'b0;
        idx      = 0;
        for (int i = 0; i < 80; i++) begin
            col = ~(4'b1000 >> idx);
            idx = (idx + 1) % 4;
            tick;
            if (row != 4'b1111) row_bad = 1'b1;
            if (key_done) done_bad = 1'b1;
        end
        col = 4'b1111;
        checks++; if (row_bad) begin errors++; $display("FAIL midrst_key2_played: got row activity expected none"); end
        checks++; if (done_bad) begin errors++; $display("FAIL midrst_spurious_done: got key_done expected none"); end
        $display("reset_mid: queue flushed");
    endtask

    task automatic test_loopback;
        logic [3:0] seq [4];
        logic [3:0] got [4];
        int         rises;
        int         falls;
        int         dones;
        logic       prev_bp;
        seq = '{4'h1, 4'hF, 4'hA, 4'h0};
        for (int i = 0; i < 4; i++) begin
            lif.key_code  = seq[i];
            lif.key_valid = 1'b1;
            tick;
        end
        lif.key_valid = 1'b0;
        rises   = 0;
        falls   = 0;
        dones   = 0;
        prev_bp = button_pressed;
        for (int i = 0; i < 1750; i++) begin
            tick;
            if (button_pressed && !prev_bp) begin
                if (rises < 4) got[rises] = dec_out;
                rises++;
                $display("loopback: decoder reports %h", dec_out);
            end
            if (!button_pressed && prev_bp) falls++;
            if (lb_done) dones++;
            prev_bp = button_pressed;
        end
        checks++; if (rises != 4) begin errors++; $display("FAIL lb_rises: got %0d expected 4", rises); end
        checks++; if (falls != 4) begin errors++; $display("FAIL lb_falls: got %0d expected 4", falls); end
        checks++; if (dones != 4) begin errors++; $display("FAIL lb_done_cnt: got %0d expected 4", dones); end
        for (int i = 0; i < 4; i++) begin
            if (i < rises) begin
                checks++; if (got[i] !== seq[i]) begin errors++; $display("FAIL lb_code: slot %0d got %h expected %h", i, got[i], seq[i]); end
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        kif.key_code  = 4'h0;
        kif.key_valid = 1'b0;
        lif.key_code  = 4'h0;
        lif.key_valid = 1'b0;
        col           = 4'b1111;
        test_reset;
        test_single;
        test_full_map;
        test_fifo_full;
        test_reset_mid;
        test_loopback;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
